// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running raster timing generator (coordinates, syncs, blank, frame count, vblank/line interrupt)
// Ports: clk, rst_n (async active-low); cli clears the sticky interrupt; irq_line_en/irq_line select an extra
// scanline interrupt; x/y are the presented pixel coordinates; hsync/vsync/blank/frame describe that same x,y.
module vga_sync_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
  input  logic        irq_line_en,
  input  logic [9:0]  irq_line,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [7:0]  frame,
  output logic        interrupt
);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic        x_wrap;
  logic        set;
  logic [10:0] x_n;
  logic [9:0]  y_n;
  logic [7:0]  frame_n;
  // Decode from next-state counters so registered syncs line up with the registered x,y.
  // y_n only reaches values below V_TOTAL, so an out-of-range irq_line can never match.
  always_comb begin
    x_wrap  = x == H_LAST;
    x_n     = x_wrap ? '0 : x + 11'd1;
    y_n     = x_wrap ? (y == V_LAST ? '0 : y + 10'd1) : y;
    frame_n = (x_wrap && y == V_LAST) ? frame + 8'd1 : frame;
    set     = x_wrap && (y_n == V_VIS || (irq_line_en && y_n == irq_line));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      frame     <= '0;
      blank     <= 1'b0;
      hsync     <= ~HSYNC_POL;
      vsync     <= ~VSYNC_POL;
      interrupt <= 1'b0;
    end else begin
      x         <= x_n;
      y         <= y_n;
      frame     <= frame_n;
      blank     <= x_n >= H_VIS || y_n >= V_VIS;
      hsync     <= (x_n >= HS_ON && x_n < HS_OFF) ? HSYNC_POL : ~HSYNC_POL;
      vsync     <= (y_n >= VS_ON && y_n < VS_OFF) ? VSYNC_POL : ~VSYNC_POL;
      interrupt <= set | (interrupt & ~cli);
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen on a shrunken raster (20x12 per frame)
module tb_vga_sync_gen;
  localparam int HA = 12, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cli = 1'b0;
  logic        irq_line_en = 1'b0;
  logic [9:0]  irq_line = '0;
  logic [10:0] x;
  logic [9:0]  y;
  logic        hsync, vsync, blank, interrupt;
  logic [7:0]  frame;
  logic [32:0] obs;
  logic [32:0] q[$];
  int          n_cmp = 0, n_bad = 0;
  int          mx = 0, my = 0, mf = 0;
  bit          mi = 1'b0;
  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cli(cli), .irq_line_en(irq_line_en), .irq_line(irq_line),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .blank(blank), .frame(frame), .interrupt(interrupt)
  );
  assign obs = {x, y, hsync, vsync, blank, frame, interrupt};
  always #5 clk = ~clk;
  function automatic logic [32:0] pack(int px, int py, int pf, bit pi);
    logic hs, vs, bl;
    hs = (px >= HA + HFP && px < HA + HFP + HS) ? 1'b0 : 1'b1;
    vs = (py >= VA + VFP && py < VA + VFP + VS) ? 1'b0 : 1'b1;
    bl = px >= HA || py >= VA;
    return {11'(px), 10'(py), hs, vs, bl, 8'(pf), pi};
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (model x=%0d y=%0d)", tag, got, exp, mx, my);
    end
  endtask
  task automatic step();
    bit wrap, set;
    wrap = mx == HT - 1;
    mx = wrap ? 0 : mx + 1;
    if (wrap) begin
      if (my == VT - 1) begin
        my = 0;
        mf = (mf + 1) % 256;
      end else my = my + 1;
    end
    set = wrap && (my == VA || (irq_line_en && my == int'(irq_line)));
    mi = set | (mi & ~cli);
    q.push_back(pack(mx, my, mf, mi));
    @(posedge clk);
    #1;
    check("pixel", 64'(obs), 64'(q.pop_front()));
  endtask
  task automatic run(int n, int mode);
    for (int i = 0; i < n; i++) begin
      cli = mode == 0 ? 1'b0 : mode == 2 ? 1'b1 : ($urandom_range(0, 7) == 0);
      step();
    end
    cli = 1'b0;
  endtask
  initial begin
    #12;
    check("reset_state", 64'(obs), 64'(pack(0, 0, 0, 0)));
    rst_n = 1'b1;
    run(FT + 10, 0);
    check("irq_held", 64'(interrupt), 64'd1);
    check("frame_one", 64'(frame), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'(obs), 64'(pack(0, 0, 0, 0)));
    mx = 0; my = 0; mf = 0; mi = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check("x_after_rst", 64'(x), 64'd1);
    run(FT - 1, 0);
    check("frame_wrap1", 64'({x, y, frame}), 64'({11'd0, 10'd0, 8'd1}));
    run(2 * FT, 1);
    irq_line_en = 1'b1;
    irq_line = 10'd3;
    run(3 * FT, 1);
    run(FT, 2);
    irq_line = 10'(VT - 1);
    run(2 * FT, 1);
    irq_line = 10'd900;
    run(2 * FT, 1);
    irq_line_en = 1'b0;
    irq_line = 10'd3;
    run(2 * FT, 1);
    for (int f = 13; f < 256; f++) begin
      irq_line_en = 1'($urandom_range(0, 1));
      irq_line = 10'($urandom_range(0, VT + 2));
      run(FT, 1);
    end
    check("frame_wrap256", 64'({x, y, frame}), 64'({11'd0, 10'd0, 8'd0}));
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
